acc_normalize: RTL and testbench



---
 rtl/pe_pkg.sv | 25 ++
 rtl/lead_one_detect.sv | 24 ++
 rtl/acc_normalize.sv | 181 ++++++++++++++++++
 tb/tb_acc_normalize.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and result types for the PE accumulate/normalize path.
// Default widths describe a half-precision-style result built from a 16-bit aligned sum.
package pe_pkg;

  localparam int ACC_EXP_WIDTH = 6;
  localparam int ACC_MAN_WIDTH = 16;
  localparam int ACC_FRAC_BITS = 12;
  localparam int OUT_EXP_WIDTH = 5;
  localparam int OUT_MAN_WIDTH = 10;
  // Output bias (15) minus the summed activation/weight bias (16).
  localparam int EXP_OFFSET    = -1;

  typedef struct packed {
    logic                     sign;
    logic [OUT_EXP_WIDTH-1:0] exp;
    logic [OUT_MAN_WIDTH-1:0] man;
  } fp_out_t;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic udf;
  } fp_flags_t;

endpackage

// File: rtl/lead_one_detect.sv
// Combinational priority encoder: index of the most significant set bit.
// found is low when vec is all zeros, in which case lead is 0.
module lead_one_detect #(
  parameter int W  = 16,
  parameter int LW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [LW-1:0] lead,
  output logic          found
);

  always_comb begin
    lead  = '0;
    found = 1'b0;
    // Ascending scan, so the highest set bit is the last one to win.
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        lead  = LW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_normalize.sv
// Renormalizes an aligned two's-complement dot-product sum into sign/exponent/mantissa.
// Pipeline: S1 abs value, S2 leading-one shift + rebias, S3 classify, then output register.
module acc_normalize #(
  parameter int ACC_EXP_WIDTH = pe_pkg::ACC_EXP_WIDTH,
  parameter int ACC_MAN_WIDTH = pe_pkg::ACC_MAN_WIDTH,
  parameter int ACC_FRAC_BITS = pe_pkg::ACC_FRAC_BITS,
  parameter int OUT_EXP_WIDTH = pe_pkg::OUT_EXP_WIDTH,
  parameter int OUT_MAN_WIDTH = pe_pkg::OUT_MAN_WIDTH,
  parameter int EXP_OFFSET    = pe_pkg::EXP_OFFSET
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ACC_MAN_WIDTH-1:0] acc_sum,
  input  logic [ACC_EXP_WIDTH-1:0] acc_exp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [OUT_EXP_WIDTH-1:0] out_exp,
  output logic [OUT_MAN_WIDTH-1:0] out_man,
  output logic                     out_zero,
  output logic                     out_ovf,
  output logic                     out_udf
);

  import pe_pkg::*;

  localparam int LW = (ACC_MAN_WIDTH > 1) ? $clog2(ACC_MAN_WIDTH) : 1;
  localparam int EW = ACC_EXP_WIDTH + 3;
  localparam logic signed [EW-1:0] E_OVF  = EW'((2 ** OUT_EXP_WIDTH) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  // Stage registers
  logic                     s1_valid, s1_sign, s1_zero;
  logic [ACC_MAN_WIDTH-1:0] s1_mag;
  logic [ACC_EXP_WIDTH-1:0] s1_exp;

  logic                     s2_valid, s2_sign, s2_zero;
  logic [OUT_MAN_WIDTH-1:0] s2_man;
  logic signed [EW-1:0]     s2_e;

  logic                     s3_valid, s3_sign;
  logic [OUT_EXP_WIDTH-1:0] s3_exp;
  logic [OUT_MAN_WIDTH-1:0] s3_man;
  fp_flags_t                s3_flags;

  // Handshake: a transfer happens on a rising edge where valid && ready. A stage
  // loads when it is empty or its successor loads in the same cycle, so bubbles
  // collapse and a full pipeline moves one entry per cycle while out_ready is high.
  logic ld1, ld2, ld3, ld_out;
  assign ld_out   = !out_valid || out_ready;
  assign ld3      = !s3_valid  || ld_out;
  assign ld2      = !s2_valid  || ld3;
  assign ld1      = !s1_valid  || ld2;
  assign in_ready = ld1;

  logic                     in_sign, in_zero;
  logic [ACC_MAN_WIDTH-1:0] in_mag;
  assign in_sign = acc_sum[ACC_MAN_WIDTH-1];
  assign in_mag  = in_sign ? (~acc_sum + ACC_MAN_WIDTH'(1)) : acc_sum;
  assign in_zero = (acc_sum == '0);

  logic [LW-1:0] lead;
  logic          lead_found;

  lead_one_detect #(
    .W  (ACC_MAN_WIDTH),
    .LW (LW)
  ) u_lead_one_detect (
    .vec   (s1_mag),
    .lead  (lead),
    .found (lead_found)
  );

  logic [OUT_MAN_WIDTH-1:0] s2_man_next;
  logic signed [EW-1:0]     s2_e_next;

  always_comb begin
    s2_man_next = '0;
    // Land the leading one on bit OUT_MAN_WIDTH; the hidden one falls off the top.
    if (lead_found) begin
      if (int'(lead) < OUT_MAN_WIDTH)
        s2_man_next = OUT_MAN_WIDTH'(s1_mag << (OUT_MAN_WIDTH - int'(lead)));
      else
        s2_man_next = OUT_MAN_WIDTH'(s1_mag >> (int'(lead) - OUT_MAN_WIDTH));
    end
    s2_e_next = EW'(s1_exp) + EW'(lead) - EW'(ACC_FRAC_BITS) + EW'(EXP_OFFSET);
  end

  logic                     s3_sign_next;
  logic [OUT_EXP_WIDTH-1:0] s3_exp_next;
  logic [OUT_MAN_WIDTH-1:0] s3_man_next;
  fp_flags_t                s3_flags_next;

  always_comb begin
    s3_sign_next  = s2_sign;
    s3_exp_next   = '0;
    s3_man_next   = '0;
    s3_flags_next = '0;
    if (s2_zero) begin
      s3_sign_next       = 1'b0;
      s3_flags_next.zero = 1'b1;
    end else if (s2_e >= E_OVF) begin
      s3_exp_next       = '1;
      s3_flags_next.ovf = 1'b1;
    end else if (s2_e <= E_ZERO) begin
      s3_flags_next.udf = 1'b1;
    end else begin
      s3_exp_next = s2_e[OUT_EXP_WIDTH-1:0];
      s3_man_next = s2_man;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_mag    <= '0;
      s1_exp    <= '0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_man    <= '0;
      s2_e      <= '0;
      s3_sign   <= 1'b0;
      s3_exp    <= '0;
      s3_man    <= '0;
      s3_flags  <= '0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_man   <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      out_udf   <= 1'b0;
    end else begin
      if (clear) begin
        s1_valid  <= 1'b0;
        s2_valid  <= 1'b0;
        s3_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (ld1)    s1_valid  <= in_valid;
        if (ld2)    s2_valid  <= s1_valid;
        if (ld3)    s3_valid  <= s2_valid;
        if (ld_out) out_valid <= s3_valid;
      end
      if (ld1 && in_valid) begin
        s1_sign <= in_sign;
        s1_zero <= in_zero;
        s1_mag  <= in_mag;
        s1_exp  <= acc_exp;
      end
      if (ld2 && s1_valid) begin
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_man  <= s2_man_next;
        s2_e    <= s2_e_next;
      end
      if (ld3 && s2_valid) begin
        s3_sign  <= s3_sign_next;
        s3_exp   <= s3_exp_next;
        s3_man   <= s3_man_next;
        s3_flags <= s3_flags_next;
      end
      if (ld_out && s3_valid) begin
        out_sign <= s3_sign;
        out_exp  <= s3_exp;
        out_man  <= s3_man;
        out_zero <= s3_flags.zero;
        out_ovf  <= s3_flags.ovf;
        out_udf  <= s3_flags.udf;
      end
    end
  end

endmodule

// File: tb/tb_acc_normalize.sv
// Bench for acc_normalize: directed vector table, hand-written stall/clear/reset
// sequences, and a randomized stream scored against an arithmetic reference model.
module tb_acc_normalize;
  import pe_pkg::*;

  localparam int RW = 1 + OUT_EXP_WIDTH + OUT_MAN_WIDTH + 3;

  logic                     clk = 1'b0;
  logic                     reset, clear, in_valid, in_ready;
  logic [ACC_MAN_WIDTH-1:0] acc_sum;
  logic [ACC_EXP_WIDTH-1:0] acc_exp;
  logic                     out_valid, out_ready, out_sign;
  logic [OUT_EXP_WIDTH-1:0] out_exp;
  logic [OUT_MAN_WIDTH-1:0] out_man;
  logic                     out_zero, out_ovf, out_udf;

  acc_normalize dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_sum   (acc_sum),
    .acc_exp   (acc_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_man   (out_man),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_udf   (out_udf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference: value = sum * 2^(acc_exp - 12) in the input scale, renormalized.
  function automatic logic [RW-1:0] model(input logic [15:0] sum, input logic [5:0] ex);
    int v, mag, lead, e, man;
    logic s;
    v = int'($signed(sum));
    if (v == 0) return {1'b0, 5'd0, 10'd0, 3'b100};
    s    = (v < 0);
    mag  = s ? -v : v;
    lead = 0;
    while ((mag >> (lead + 1)) != 0) lead++;
    man = ((mag * 1024) >> lead) % 1024;
    e   = int'(ex) + lead - 12 - 1;
    if (e >= 31) return {s, 5'h1f, 10'd0, 3'b010};
    if (e <= 0)  return {s, 5'd0, 10'd0, 3'b001};
    return {s, e[4:0], man[9:0], 3'b000};
  endfunction

  logic [RW-1:0] prev_out;
  logic          prev_stall = 1'b0;

  always @(negedge clk) begin
    logic [RW-1:0] act;
    act = {out_sign, out_exp, out_man, out_zero, out_ovf, out_udf};
    if (prev_stall) check("stall_hold", 32'(act), 32'(prev_out));
    if (out_valid && !reset)
      check("one_flag", 32'($countones({out_zero, out_ovf, out_udf}) <= 1), 32'd1);
    if (out_valid && out_ready && !reset) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h with empty queue at %0t", act, $time);
      end else begin
        check("scoreboard", 32'(act), 32'(exp_q.pop_front()));
        pops++;
      end
    end
    if (reset || clear) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(acc_sum, acc_exp));
    prev_stall = out_valid && !out_ready && !reset && !clear;
    prev_out   = act;
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] s, input logic [5:0] e);
    int n;
    logic f;
    in_valid = 1'b1;
    acc_sum  = s;
    acc_exp  = e;
    n = 0;
    f = 1'b0;
    while (!f && n < 50) begin
      @(negedge clk);
      f = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!f) timeout_fail("send");
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [15:0] rand_sum();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(0, 15));
      2:       return -16'($urandom_range(1, 16));
      default: return ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
    endcase
  endfunction

  typedef struct {
    logic [15:0] sum;
    logic [5:0]  ex;
    logic [15:0] word;
    logic [2:0]  flg;
  } vec_t;

  vec_t vt[16];

  // ---------------- test sequence ----------------
  initial begin
    int lat, got, bad, n, pops0;
    logic f;
    fp_out_t w;

    vt[0]  = '{16'h1000, 6'd16, 16'h3C00, 3'b000};
    vt[1]  = '{16'hE800, 6'd16, 16'hBE00, 3'b000};
    vt[2]  = '{16'h0003, 6'd16, 16'h1200, 3'b000};
    vt[3]  = '{16'h7FFF, 6'd40, 16'h7C00, 3'b010};
    vt[4]  = '{16'h0001, 6'd5,  16'h0000, 3'b001};
    vt[5]  = '{16'hFFFF, 6'd5,  16'h8000, 3'b001};
    vt[6]  = '{16'h0000, 6'd16, 16'h0000, 3'b100};
    vt[7]  = '{16'h8000, 6'd16, 16'hC800, 3'b000};
    vt[8]  = '{16'h1000, 6'd32, 16'h7C00, 3'b010};
    vt[9]  = '{16'h1000, 6'd31, 16'h7800, 3'b000};
    vt[10] = '{16'h1000, 6'd1,  16'h0000, 3'b001};
    vt[11] = '{16'h1000, 6'd2,  16'h0400, 3'b000};
    vt[12] = '{16'h1FFF, 6'd16, 16'h3FFF, 3'b000};
    vt[13] = '{16'hC000, 6'd16, 16'hC400, 3'b000};
    vt[14] = '{16'h0001, 6'd20, 16'h1C00, 3'b000};
    vt[15] = '{16'h0000, 6'd63, 16'h0000, 3'b100};

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
    acc_sum = '0; acc_exp = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'({out_sign, out_exp, out_man, out_zero, out_ovf, out_udf}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid_after", 32'(out_valid), 32'd0);

    // Directed table, one vector at a time, with latency measurement.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; acc_sum = vt[i].sum; acc_exp = vt[i].ex;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0; got = 0;
      while (got == 0 && lat < 10) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        got = int'(out_valid);
      end
      if (got == 0) timeout_fail("vec_out_valid");
      else begin
        w = '{out_sign, out_exp, out_man};
        check("vec_latency", 32'(lat), 32'd3);
        check("vec_word", 32'(w), 32'(vt[i].word));
        check("vec_flags", 32'({out_zero, out_ovf, out_udf}), 32'(vt[i].flg));
      end
    end
    @(posedge clk); #1;

    // Backpressure: 6 back-to-back inputs with output stalled for 4 cycles.
    out_ready = 1'b0;
    pops0 = pops;
    fork
      begin
        for (int k = 0; k < 6; k++) send(16'h1000 + 16'(k * 16'h0155), 6'(14 + k));
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        if (!out_valid) timeout_fail("bp_first_valid");
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid_held", 32'(out_valid), 32'd1);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_count", 32'(pops - pops0), 32'd6);

    // Randomized stream with random valid and random backpressure.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      f = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || f) begin
        in_valid = ($urandom_range(0, 3) != 0);
        acc_sum  = rand_sum();
        acc_exp  = 6'($urandom_range(0, 63));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand_drain");

    // clear with two entries in flight plus one being offered.
    @(posedge clk); #1 out_ready = 1'b0;
    send(16'h1000, 6'd16);
    send(16'h2000, 6'd16);
    in_valid = 1'b1; acc_sum = 16'h3000; acc_exp = 6'd16; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clear_out_valid", 32'(out_valid), 32'd0);
    check("clear_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    bad = 0;
    repeat (8) begin @(negedge clk); if (out_valid) bad++; end
    check("clear_no_ghost", 32'(bad), 32'd0);

    // reset mid-stream with a result parked at the output.
    @(posedge clk); #1 out_ready = 1'b0;
    send(16'h1000, 6'd16);
    send(16'h7FFF, 6'd40);
    send(16'h0001, 6'd5);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) timeout_fail("rst_fill");
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'({out_sign, out_exp, out_man, out_zero, out_ovf, out_udf}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    bad = 0;
    repeat (8) begin @(negedge clk); if (out_valid) bad++; end
    check("rst_no_ghost", 32'(bad), 32'd0);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
